// File: rtl/fpga_state_writer_pkg.sv
// Shared controller parameters: BRAM address map, firmware version and the
// bit layout of the FPGA_STATE word.
package fpga_state_writer_pkg;

  typedef logic [7:0] bram_addr_t;

  localparam bram_addr_t ADDR_CTL_FLAG          = 8'h00;
  localparam bram_addr_t ADDR_FPGA_STATE        = 8'h01;
  localparam bram_addr_t ADDR_VERSION_NUM_MAJOR = 8'h02;
  localparam bram_addr_t ADDR_VERSION_NUM_MINOR = 8'h03;

  localparam logic [7:0] VersionNumMajor = 8'h91;
  localparam logic [7:0] VersionNumMinor = 8'h00;

  localparam int FPGA_STATE_BIT_THERMO      = 0;
  localparam int FPGA_STATE_BIT_MOD_SEGMENT = 1;
  localparam int FPGA_STATE_BIT_STM_SEGMENT = 2;
  localparam int FPGA_STATE_BIT_IS_STM_MODE = 3;

  // Assemble the FPGA_STATE word from the individual status bits.
  function automatic logic [15:0] pack_state(input logic thermo,
                                             input logic mod_segment,
                                             input logic stm_segment,
                                             input logic is_stm_mode);
    logic [15:0] word;
    word                             = '0;
    word[FPGA_STATE_BIT_THERMO]      = thermo;
    word[FPGA_STATE_BIT_MOD_SEGMENT] = mod_segment;
    word[FPGA_STATE_BIT_STM_SEGMENT] = stm_segment;
    word[FPGA_STATE_BIT_IS_STM_MODE] = is_stm_mode;
    return word;
  endfunction

endpackage

// File: rtl/fpga_state_writer.sv
// Writes the version words once after reset, then mirrors the live FPGA
// status bits into the controller BRAM, rate-limited by MinInterval and
// arbitrated through a WR_REQ/WR_GNT handshake.
module fpga_state_writer
  import fpga_state_writer_pkg::*;
#(
  parameter int unsigned MinInterval = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        THERMO,
  input  logic        MOD_SEGMENT,
  input  logic        STM_SEGMENT,
  input  logic        IS_STM_MODE,
  output logic        WR_REQ,
  input  logic        WR_GNT,
  output logic        WR_EN,
  output bram_addr_t  WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic        INIT_DONE
);

  typedef enum logic [1:0] {
    INIT_MAJOR,
    INIT_MINOR,
    IDLE,
    WR_STATE
  } state_e;

  localparam logic [15:0] MIN_INTERVAL = 16'(MinInterval);

  state_e      state_q, state_d;
  bram_addr_t  addr_q, addr_d;        // last presented address, held when idle
  logic [15:0] data_q, data_d;        // last presented data / state snapshot
  logic        init_done_q, init_done_d;
  logic        dirty_q, dirty_d;
  logic [15:0] last_q, last_d;        // last FPGA_STATE value accepted
  logic [15:0] interval_q, interval_d;
  logic        gap_q, gap_d;          // forces one idle cycle after an accept
  logic [15:0] live_word;
  logic        accept;

  assign live_word = pack_state(THERMO, MOD_SEGMENT, STM_SEGMENT, IS_STM_MODE);

  // Reset masks the request combinationally so an in-flight write aborts at once.
  assign WR_REQ    = (state_q != IDLE) && !gap_q && !RST;
  assign WR_EN     = WR_REQ && WR_GNT;
  assign accept    = WR_EN;
  assign INIT_DONE = init_done_q && !RST;

  // Present the version constants while requesting them, otherwise hold.
  always_comb begin
    WR_ADDR = addr_q;
    WR_DATA = data_q;
    if (RST) begin
      WR_ADDR = ADDR_CTL_FLAG;
      WR_DATA = '0;
    end else if (WR_REQ && state_q == INIT_MAJOR) begin
      WR_ADDR = ADDR_VERSION_NUM_MAJOR;
      WR_DATA = {8'h00, VersionNumMajor};
    end else if (WR_REQ && state_q == INIT_MINOR) begin
      WR_ADDR = ADDR_VERSION_NUM_MINOR;
      WR_DATA = {8'h00, VersionNumMinor};
    end
  end

  // Next-state, change detection, snapshot and interval bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    dirty_d     = dirty_q;
    last_d      = last_q;
    interval_d  = (interval_q == 16'hFFFF) ? interval_q : interval_q + 16'd1;
    gap_d       = accept;

    // While a state write is pending the snapshot owns the comparison; any
    // change is picked up against the new last value once it is accepted.
    if (state_q != WR_STATE && live_word != last_q) begin
      dirty_d = 1'b1;
    end

    unique case (state_q)
      INIT_MAJOR: begin
        if (accept) begin
          addr_d  = ADDR_VERSION_NUM_MAJOR;
          data_d  = {8'h00, VersionNumMajor};
          state_d = INIT_MINOR;
        end
      end
      INIT_MINOR: begin
        if (accept) begin
          addr_d      = ADDR_VERSION_NUM_MINOR;
          data_d      = {8'h00, VersionNumMinor};
          state_d     = IDLE;
          init_done_d = 1'b1;
          dirty_d     = 1'b1;  // guarantees the first state write
        end
      end
      IDLE: begin
        if (dirty_q && interval_q >= MIN_INTERVAL) begin
          addr_d  = ADDR_FPGA_STATE;
          data_d  = live_word;
          dirty_d = 1'b0;
          state_d = WR_STATE;
        end
      end
      WR_STATE: begin
        if (accept) begin
          last_d     = data_q;
          interval_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = INIT_MAJOR;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) begin
      state_q     <= INIT_MAJOR;
      addr_q      <= ADDR_CTL_FLAG;
      data_q      <= '0;
      init_done_q <= 1'b0;
      dirty_q     <= 1'b0;
      last_q      <= '0;
      interval_q  <= 16'hFFFF;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      dirty_q     <= dirty_d;
      last_q      <= last_d;
      interval_q  <= interval_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: tb/tb_fpga_state_writer.sv
// Scoreboard bench for fpga_state_writer: stimulus pushes the writes the
// controller BRAM must see, a monitor pops them on every WR_EN and checks
// the handshake rules each cycle.
module tb_fpga_state_writer;

  localparam int MIN_IV = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        THERMO, MOD_SEGMENT, STM_SEGMENT, IS_STM_MODE;
  logic        WR_GNT;
  logic        WR_REQ, WR_EN, INIT_DONE;
  logic [7:0]  WR_ADDR;
  logic [15:0] WR_DATA;

  fpga_state_writer #(.MinInterval(MIN_IV)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .THERMO     (THERMO),
    .MOD_SEGMENT(MOD_SEGMENT),
    .STM_SEGMENT(STM_SEGMENT),
    .IS_STM_MODE(IS_STM_MODE),
    .WR_REQ     (WR_REQ),
    .WR_GNT     (WR_GNT),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .INIT_DONE  (INIT_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         gnt_rand = 1'b0;
  logic [3:0] cur = 4'h0;   // {IS_STM_MODE, STM_SEGMENT, MOD_SEGMENT, THERMO}

  always @(posedge CLK) cyc <= cyc + 1;

  // Random grant generator for the soak phase.
  always @(posedge CLK) begin
    if (gnt_rand) begin
      #1;
      WR_GNT = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_inputs(input logic [3:0] v);
    cur = v;
    {IS_STM_MODE, STM_SEGMENT, MOD_SEGMENT, THERMO} = v;
  endtask

  task automatic push(input logic [7:0] addr, input logic [15:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && !WR_REQ; i++) tick(1);
    check("req_timeout", WR_REQ, 1);
  endtask

  // Reset, then expect both version words and a state write of the live bits.
  task automatic do_reset(input logic gnt);
    WR_GNT = gnt;
    RST    = 1'b1;
    exp_q.delete();
    tick(3);
    push(8'h02, 16'h0091);
    push(8'h03, 16'h0000);
    push(8'h01, {12'h000, cur});
    RST = 1'b0;
    @(negedge CLK);
    check("req_after_reset", WR_REQ, 1);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: handshake rules every cycle, scoreboard pop on every accept.
  logic        prev_valid, prev_req, prev_en;
  logic [7:0]  prev_addr;
  logic [15:0] prev_data;
  int          last_acc = -1;

  always @(negedge CLK) begin
    if (RST) begin
      check("rst_wr_req", WR_REQ, 0);
      check("rst_wr_en", WR_EN, 0);
      check("rst_wr_addr", WR_ADDR, 8'h00);
      check("rst_wr_data", WR_DATA, 16'h0000);
      check("rst_init_done", INIT_DONE, 0);
      prev_valid = 1'b0;
      prev_req   = 1'b0;
      prev_en    = 1'b0;
      last_acc   = -1;
    end else begin
      check("wr_en_rule", WR_EN, WR_REQ & WR_GNT);
      if (prev_valid && prev_en) check("no_back_to_back", WR_REQ, 0);
      if (prev_valid && (prev_req || !WR_REQ) && !prev_en && WR_REQ) begin
        check("req_addr_stable", WR_ADDR, prev_addr);
        check("req_data_stable", WR_DATA, prev_data);
      end
      if (prev_valid && !WR_REQ) begin
        check("idle_addr_hold", WR_ADDR, prev_addr);
        check("idle_data_hold", WR_DATA, prev_data);
      end
      if (WR_REQ && !prev_req && WR_ADDR == 8'h01 && last_acc >= 0)
        check("min_interval", (cyc - last_acc) >= MIN_IV, 1);
      if (WR_EN) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   WR_ADDR, WR_DATA);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("write_addr", WR_ADDR, w.addr);
          check("write_data", WR_DATA, w.data);
          check("init_done_at_write", INIT_DONE, w.addr == 8'h01);
        end
        if (WR_ADDR == 8'h01) last_acc = cyc;
      end
      prev_valid = 1'b1;
      prev_req   = WR_REQ;
      prev_en    = WR_EN;
      prev_addr  = WR_ADDR;
      prev_data  = WR_DATA;
    end
  end

  initial begin
    logic [3:0] v1, v2;
    int         k;
    RST    = 1'b1;
    WR_GNT = 1'b0;
    set_inputs(4'h0);

    // Init sequence with grant tied high.
    do_reset(1'b1);
    wait_drain(20);
    check("init_done_high", INIT_DONE, 1);

    // Grant withheld for 50 cycles during INIT_MAJOR.
    do_reset(1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      check("stall_req", WR_REQ, 1);
      check("stall_addr", WR_ADDR, 8'h02);
    end
    check("stall_data", WR_DATA, 16'h0091);
    @(posedge CLK);
    #1;
    WR_GNT = 1'b1;
    wait_drain(20);

    // Latency: THERMO rises with the interval satisfied.
    tick(MIN_IV + 4);
    set_inputs(4'h1);
    push(8'h01, 16'h0001);
    @(negedge CLK);
    check("lat_t0_req", WR_REQ, 0);
    @(negedge CLK);
    check("lat_t1_req", WR_REQ, 0);
    @(negedge CLK);
    check("lat_t2_req", WR_REQ, 1);
    check("lat_t2_addr", WR_ADDR, 8'h01);
    check("lat_t2_data", WR_DATA, 16'h0001);

    // Toggle away and back right after a write: one rate-limited write of the latest value.
    @(posedge CLK);
    #1;
    set_inputs(4'h0);
    tick(3);
    set_inputs(4'h1);
    push(8'h01, 16'h0001);
    wait_drain(60);

    // MOD_SEGMENT changes while a state write is pending.
    tick(MIN_IV + 4);
    WR_GNT = 1'b0;
    set_inputs(4'h0);
    push(8'h01, 16'h0000);
    wait_req(10);
    tick(2);
    set_inputs(4'h2);
    push(8'h01, 16'h0002);
    tick(8);
    WR_GNT = 1'b1;
    wait_drain(60);

    // Random soak: two distinct changes per trial with random grants.
    gnt_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick(MIN_IV + 3);
      v1 = 4'($urandom_range(0, 15));
      if (v1 == cur) v1 = v1 ^ 4'h1;
      set_inputs(v1);
      push(8'h01, {12'h000, v1});
      k = $urandom_range(2, 30);
      tick(k);
      v2 = 4'($urandom_range(0, 15));
      if (v2 == v1) v2 = v2 ^ 4'h8;
      set_inputs(v2);
      push(8'h01, {12'h000, v2});
      wait_drain(300);
    end
    gnt_rand = 1'b0;
    tick(1);
    WR_GNT = 1'b1;
    tick(MIN_IV + 4);

    // Reset pulsed while a state write is pending without grant.
    WR_GNT = 1'b0;
    set_inputs(cur ^ 4'h1);
    wait_req(10);
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    check("abort_wr_en", WR_EN, 0);
    check("abort_wr_req", WR_REQ, 0);
    check("abort_init_done", INIT_DONE, 0);
    @(posedge CLK);
    #1;
    do_reset(1'b1);
    wait_drain(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
